// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response channel from the execute stage plus the
// data-memory port. The slave modport is the load/store unit itself (it is the
// target of execute-stage requests and drives the memory port). The master
// modport is its environment: the execute stage and the memory/IO block.
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [2:0]            req_funct3;
    logic [31:0]           req_address;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic [31:0]           resp_rdata;
    logic                  resp_error;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [3:0]            mem_byteena;
    logic [31:0]           mem_data;
    logic                  mem_wren;
    logic [31:0]           mem_q;

    modport slave (
        input  req_valid, req_write, req_funct3, req_address, req_wdata, mem_q,
        output req_ready, resp_valid, resp_rdata, resp_error,
               mem_address, mem_byteena, mem_data, mem_wren
    );

    modport master (
        output req_valid, req_write, req_funct3, req_address, req_wdata, mem_q,
        input  req_ready, resp_valid, resp_rdata, resp_error,
               mem_address, mem_byteena, mem_data, mem_wren
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the data-memory port. Takes one RV32I
// load/store at a time, drives word address / byte enables / write data,
// absorbs RAM or IO read latency and returns aligned, extended load data.
// Optional feature macro: LSU_MISALIGNED_SPLIT_EN -- when defined, misaligned
// accesses are serviced (word-crossing ones as two passes, low word first)
// instead of being answered with resp_error.
module load_store_unit #(
    parameter int ADDR_WIDTH  = 12,
    parameter int IO_READ_BIT = 10,
    parameter int RAM_LATENCY = 1,
    parameter int IO_LATENCY  = 2
) (
    input  logic             clock,
    input  logic             reset,
    load_store_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t                state;
    state_t                next_state;

    logic                  is_write;
    logic [2:0]            funct3;
    logic [1:0]            offset;
    logic [ADDR_WIDTH-1:0] word_address;
    logic [31:0]           wdata;
    logic                  error;
    logic                  pass;
    logic [7:0]            wait_count;
    logic [63:0]           read_word;

    logic                  accept;
    logic                  req_legal;
    logic                  req_misaligned;
    logic                  req_error;
    logic [7:0]            base_mask;
    logic [7:0]            lane_mask;
    logic [63:0]           lane_data;
    logic                  second_pass_needed;
    logic [7:0]            access_latency;
    logic [31:0]           aligned;
    logic [31:0]           extended;

    wire unused_address_bits = &{1'b0, bus.req_address[31:ADDR_WIDTH+2]};

    assign accept = bus.req_valid && bus.req_ready;

    // Decode legality and alignment of the incoming request before accepting it
    always_comb begin
        req_legal = 1'b0;
        case (bus.req_funct3)
            3'b000, 3'b001, 3'b010: req_legal = 1'b1;
            3'b100, 3'b101:         req_legal = !bus.req_write;
            default:                req_legal = 1'b0;
        endcase
`ifdef LSU_MISALIGNED_SPLIT_EN
        req_misaligned = 1'b0;
`else
        req_misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_address[0]) ||
                         ((bus.req_funct3[1:0] == 2'b10) && (bus.req_address[1:0] != 2'b00));
`endif
        req_error = !req_legal || req_misaligned;
    end

    // Byte lanes over a two-word window; the upper nibble is the second pass
    always_comb begin
        case (funct3[1:0])
            2'b00:   base_mask = 8'b0000_0001;
            2'b01:   base_mask = 8'b0000_0011;
            default: base_mask = 8'b0000_1111;
        endcase
        lane_mask = base_mask << offset;
        lane_data = {32'b0, wdata} << {offset, 3'b000};
`ifdef LSU_MISALIGNED_SPLIT_EN
        second_pass_needed = |lane_mask[7:4];
`else
        second_pass_needed = 1'b0;
`endif
        access_latency = word_address[IO_READ_BIT] ? 8'(IO_LATENCY - 1) : 8'(RAM_LATENCY - 1);
    end

    // Align the captured word(s) to bit 0 and sign- or zero-extend by size
    always_comb begin
        aligned = 32'(read_word >> {offset, 3'b000});
        case (funct3)
            3'b000:  extended = {{24{aligned[7]}}, aligned[7:0]};
            3'b001:  extended = {{16{aligned[15]}}, aligned[15:0]};
            3'b100:  extended = {24'b0, aligned[7:0]};
            3'b101:  extended = {16'b0, aligned[15:0]};
            default: extended = aligned;
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic; a word-crossing access loops back to ACCESS once
    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (accept) next_state = req_error ? RESP : ACCESS;
            ACCESS: begin
                if (!is_write)                        next_state = WAIT;
                else if (second_pass_needed && !pass) next_state = ACCESS;
                else                                  next_state = RESP;
            end
            WAIT:   if (wait_count == 8'd0) next_state = (second_pass_needed && !pass) ? ACCESS : RESP;
            RESP:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Request latch, pass/latency bookkeeping and read-data capture
    always_ff @(posedge clock) begin
        if (reset) begin
            is_write     <= 1'b0;
            funct3       <= 3'b000;
            offset       <= 2'b00;
            word_address <= '0;
            wdata        <= 32'b0;
            error        <= 1'b0;
            pass         <= 1'b0;
            wait_count   <= 8'd0;
            read_word    <= 64'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    is_write     <= bus.req_write;
                    funct3       <= bus.req_funct3;
                    offset       <= bus.req_address[1:0];
                    word_address <= bus.req_address[ADDR_WIDTH+1:2];
                    wdata        <= bus.req_wdata;
                    error        <= req_error;
                    pass         <= 1'b0;
                    read_word    <= 64'b0;
                end
                ACCESS: begin
                    wait_count <= access_latency;
                    if (is_write && second_pass_needed && !pass) begin
                        pass         <= 1'b1;
                        word_address <= word_address + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                WAIT: begin
                    if (wait_count != 8'd0) begin
                        wait_count <= wait_count - 8'd1;
                    end else begin
                        if (pass) read_word[63:32] <= bus.mem_q;
                        else      read_word[31:0]  <= bus.mem_q;
                        if (second_pass_needed && !pass) begin
                            pass         <= 1'b1;
                            word_address <= word_address + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Port outputs decoded from the current state and latched request
    always_comb begin
        bus.req_ready   = (state == IDLE) && !reset;
        bus.resp_valid  = (state == RESP);
        bus.resp_error  = (state == RESP) && error;
        bus.resp_rdata  = ((state == RESP) && !error && !is_write) ? extended : 32'b0;
        bus.mem_address = word_address;
        bus.mem_byteena = 4'b0000;
        bus.mem_data    = 32'b0;
        bus.mem_wren    = 1'b0;
        if (state == ACCESS || state == WAIT)
            bus.mem_byteena = pass ? lane_mask[7:4] : lane_mask[3:0];
        if (state == ACCESS) begin
            bus.mem_data = pass ? lane_data[63:32] : lane_data[31:0];
            bus.mem_wren = is_write;
        end
    end
endmodule
